// File: rtl/point_window_feeder.sv
// Streams the stored point cloud to the distance-module bank one M-point window per
// beat, with lane masking of the partial tail window and optional repeated sweeps.
module point_window_feeder #(
   parameter int N        = 16,
   parameter int M        = 16,
   parameter int CHANNELS = 4,
   parameter int SIZE_W   = 17,
   parameter int SWEEPS_W = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    abort,
   input  logic [SIZE_W-1:0]       point_cloud_size,
   input  logic [SWEEPS_W-1:0]     num_sweeps,
   output logic                    mem_rd_en,
   output logic [SIZE_W-1:0]       mem_rd_addr,
   input  logic [N*M*CHANNELS-1:0] mem_rd_data,
   output logic                    win_valid,
   input  logic                    win_ready,
   output logic [N*M*CHANNELS-1:0] win_data,
   output logic [M-1:0]            win_mask,
   output logic [SIZE_W-1:0]       win_base,
   output logic                    win_last,
   output logic [SWEEPS_W-1:0]     sweep_idx,
   output logic                    busy,
   output logic                    done
);

   localparam int W     = N * M * CHANNELS;
   localparam int SLICE = N * M;
   localparam logic [SIZE_W-1:0] M_SZ  = SIZE_W'(M);
   localparam logic [SIZE_W:0]   M_EXT = (SIZE_W + 1)'(M);
   localparam logic [SIZE_W:0]   M_M1  = (SIZE_W + 1)'(M - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   function automatic logic [M-1:0] lane_mask(input logic [SIZE_W-1:0] base,
                                              input logic [SIZE_W-1:0] size);
      logic [M-1:0] m;
      for (int k = 0; k < M; k++)
         m[k] = (({1'b0, base} + (SIZE_W + 1)'(k)) < {1'b0, size});
      return m;
   endfunction

   function automatic logic [W-1:0] apply_mask(input logic [W-1:0] d,
                                                input logic [M-1:0] m);
      logic [W-1:0] r;
      for (int c = 0; c < CHANNELS; c++)
         for (int k = 0; k < M; k++)
            r[SLICE*c + N*k +: N] = m[k] ? d[SLICE*c + N*k +: N] : '0;
      return r;
   endfunction

   state_t              state;
   logic [SIZE_W-1:0]   size_r;
   logic [SIZE_W-1:0]   nblocks_r;
   logic [SWEEPS_W-1:0] last_sweep_r;
   logic [SIZE_W-1:0]   blk;
   logic [SWEEPS_W-1:0] sw;
   logic                issue_done;

   logic                rd_vld_p1;
   logic [SIZE_W-1:0]   rd_blk_p1;
   logic [SWEEPS_W-1:0] rd_sweep_p1;
   logic                rd_last_p1;
   logic                rd_fin_p1;

   logic [1:0]          count;
   logic [W-1:0]        q_data  [2];
   logic [M-1:0]        q_mask  [2];
   logic [SIZE_W-1:0]   q_base  [2];
   logic [SWEEPS_W-1:0] q_sweep [2];
   logic                q_last  [2];
   logic                q_fin   [2];

   logic                pop;
   logic                push;
   logic [1:0]          occ_after;
   logic [1:0]          wr_idx;
   logic                rd_go;
   logic                blk_is_last;
   logic [SIZE_W-1:0]   new_base;
   logic [M-1:0]        new_mask;
   logic [W-1:0]        new_data;
   logic [SIZE_W:0]     nblocks_calc;

   // Occupancy is judged after this cycle's pop so a streaming consumer sees one window per cycle.
   assign win_valid    = (count != 2'd0);
   assign pop          = win_valid & win_ready;
   assign push         = rd_vld_p1;
   assign occ_after    = count - 2'(pop) + 2'(rd_vld_p1);
   assign wr_idx       = count - 2'(pop);
   assign rd_go        = (state == RUN) && !issue_done && !abort && (occ_after < 2'd2);
   assign blk_is_last  = (blk == nblocks_r - SIZE_W'(1));
   assign nblocks_calc = ({1'b0, point_cloud_size} + M_M1) / M_EXT;

   assign mem_rd_en    = rd_go;
   assign mem_rd_addr  = blk;

   assign new_base     = rd_blk_p1 * M_SZ;
   assign new_mask     = lane_mask(new_base, size_r);
   assign new_data     = apply_mask(mem_rd_data, new_mask);

   assign win_data     = win_valid ? q_data[0]  : '0;
   assign win_mask     = win_valid ? q_mask[0]  : '0;
   assign win_base     = win_valid ? q_base[0]  : '0;
   assign win_last     = win_valid ? q_last[0]  : 1'b0;
   assign sweep_idx    = win_valid ? q_sweep[0] : '0;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         size_r       <= '0;
         nblocks_r    <= '0;
         last_sweep_r <= '0;
         blk          <= '0;
         sw           <= '0;
         issue_done   <= 1'b0;
         rd_vld_p1    <= 1'b0;
         count        <= 2'd0;
      end else if (abort) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         blk        <= '0;
         sw         <= '0;
         issue_done <= 1'b0;
         rd_vld_p1  <= 1'b0;
         count      <= 2'd0;
      end else begin
         rd_vld_p1 <= rd_go;
         count     <= count - 2'(pop) + 2'(push);

         case (state)
            IDLE, DONE: begin
               if (start) begin
                  if (point_cloud_size == '0) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state        <= RUN;
                     busy         <= 1'b1;
                     done         <= 1'b0;
                     size_r       <= point_cloud_size;
                     nblocks_r    <= SIZE_W'(nblocks_calc);
                     last_sweep_r <= (num_sweeps == '0) ? '0 : num_sweeps - SWEEPS_W'(1);
                     blk          <= '0;
                     sw           <= '0;
                     issue_done   <= 1'b0;
                  end
               end
            end
            RUN: begin
               if (pop && q_fin[0]) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         if (rd_go) begin
            if (blk_is_last) begin
               blk <= '0;
               if (sw == last_sweep_r) issue_done <= 1'b1;
               else                    sw         <= sw + SWEEPS_W'(1);
            end else begin
               blk <= blk + SIZE_W'(1);
            end
         end
      end
   end

   // p1: metadata of the read in flight, aligned with mem_rd_data on the next cycle
   always_ff @(posedge clock) begin
      if (rd_go) begin
         rd_blk_p1   <= blk;
         rd_sweep_p1 <= sw;
         rd_last_p1  <= blk_is_last;
         rd_fin_p1   <= blk_is_last && (sw == last_sweep_r);
      end
   end

   // buffer: entry 0 drives the outputs, entry 1 is the skid slot
   always_ff @(posedge clock) begin
      if (pop) begin
         q_data[0]  <= q_data[1];
         q_mask[0]  <= q_mask[1];
         q_base[0]  <= q_base[1];
         q_sweep[0] <= q_sweep[1];
         q_last[0]  <= q_last[1];
         q_fin[0]   <= q_fin[1];
      end
      if (push) begin
         if (wr_idx == 2'd0) begin
            q_data[0]  <= new_data;
            q_mask[0]  <= new_mask;
            q_base[0]  <= new_base;
            q_sweep[0] <= rd_sweep_p1;
            q_last[0]  <= rd_last_p1;
            q_fin[0]   <= rd_fin_p1;
         end else begin
            q_data[1]  <= new_data;
            q_mask[1]  <= new_mask;
            q_base[1]  <= new_base;
            q_sweep[1] <= rd_sweep_p1;
            q_last[1]  <= rd_last_p1;
            q_fin[1]   <= rd_fin_p1;
         end
      end
   end

endmodule
